// File: rtl/icache_pkg.sv
// Shared icache geometry, derived widths, tag entry layout and the refill
// FSM encoding. The data RAM, tag RAM and refill engine all size their ports
// from these constants so the three can never disagree.
package icache_pkg;

    localparam int ICACHE_ADDR_W    = 32;   // byte-address width
    localparam int ICACHE_NUM_LINES = 256;  // sets per way
    localparam int ICACHE_LINE_W    = 64;   // line size in bytes
    localparam int ICACHE_NUM_WAYS  = 2;    // associativity
    localparam int MEM_DATA_W       = 32;   // memory word width in bits

    localparam int WORDS  = ICACHE_LINE_W * 8 / MEM_DATA_W;
    localparam int WIDX_W = $clog2(WORDS);
    localparam int SET_W  = $clog2(ICACHE_NUM_LINES);
    localparam int OFF_W  = $clog2(ICACHE_LINE_W);
    localparam int TAG_W  = ICACHE_ADDR_W - SET_W - OFF_W;
    localparam int WAY_W  = $clog2(ICACHE_NUM_WAYS);

    // Byte-offset bits below the word index inside a line.
    localparam int BOFF_W = OFF_W - WIDX_W;

    // Fill counters need one extra bit so they can hold WORDS itself.
    localparam int                CNT_W     = WIDX_W + 1;
    localparam logic [CNT_W-1:0]  CNT_WORDS = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    // Tag RAM entry as stored: {valid, tag}.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    // Refill engine states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_TAG   = 2'd3
    } refill_state_t;

endpackage

// File: rtl/icache_refill.sv
// Instruction-cache line-fill engine. Accepts one miss, reads the line from
// memory critical word first, writes each returned word into the victim way
// of the data RAM, and finally writes the tag entry (valid only if no bus
// error was seen). The tag write is always the last write of a fill, so a
// lookup can never hit on a partially filled line.
module icache_refill
    import icache_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     miss_valid_i,
    input  logic [ICACHE_ADDR_W-1:0] miss_addr_i,
    input  logic [WAY_W-1:0]         miss_way_i,
    output logic                     miss_ready_o,

    output logic                     mem_req_valid_o,
    output logic [ICACHE_ADDR_W-1:0] mem_req_addr_o,
    input  logic                     mem_req_ready_i,
    input  logic                     mem_resp_valid_i,
    input  logic [MEM_DATA_W-1:0]    mem_resp_data_i,
    input  logic                     mem_resp_err_i,

    output logic                     data_we_o,
    output logic [WAY_W-1:0]         data_way_o,
    output logic [SET_W-1:0]         data_set_o,
    output logic [WIDX_W-1:0]        data_word_o,
    output logic [MEM_DATA_W-1:0]    data_wdata_o,

    output logic                     tag_we_o,
    output logic [WAY_W-1:0]         tag_way_o,
    output logic [SET_W-1:0]         tag_set_o,
    output logic [TAG_W:0]           tag_wdata_o,

    output logic                     fill_done_o,
    output logic                     fill_err_o
);

    refill_state_t r_state;
    refill_state_t w_state_next;

    // Line being filled, latched on acceptance.
    logic [TAG_W-1:0]      r_tag;
    logic [SET_W-1:0]      r_set;
    logic [WAY_W-1:0]      r_way;
    logic [WIDX_W-1:0]     r_crit;

    // Requests issued / responses consumed in this fill, and sticky error.
    logic [CNT_W-1:0]      r_req_cnt;
    logic [CNT_W-1:0]      r_resp_cnt;
    logic                  r_err;

    // Registered data RAM write port.
    logic                  r_data_we;
    logic [WIDX_W-1:0]     r_data_word;
    logic [MEM_DATA_W-1:0] r_data_wdata;

    logic                  w_accept;
    logic                  w_req_fire;
    logic                  w_consume;
    logic                  w_write;
    logic                  w_err_next;
    logic [CNT_W-1:0]      w_req_cnt_next;
    logic [CNT_W-1:0]      w_resp_cnt_next;
    logic [WIDX_W-1:0]     w_req_word;
    logic [WIDX_W-1:0]     w_resp_word;
    tag_entry_t            w_tag_entry;
    logic                  w_unused;

    // Byte offset within a word is irrelevant: every read is a full word.
    assign w_unused = ^miss_addr_i[BOFF_W-1:0];

    assign miss_ready_o    = (r_state == S_IDLE);
    assign mem_req_valid_o = (r_state == S_FILL) && (r_req_cnt < CNT_WORDS);

    assign w_accept   = miss_valid_i && miss_ready_o;
    assign w_req_fire = mem_req_valid_o && mem_req_ready_i;

    // Only responses to requests already issued are taken; anything else is
    // a protocol violation from memory and is dropped.
    assign w_consume  = mem_resp_valid_i && (r_resp_cnt < r_req_cnt) &&
                        ((r_state == S_FILL) || (r_state == S_DRAIN));

    // Once an error has been seen, no further words of this line are written.
    assign w_write    = w_consume && !mem_resp_err_i && !r_err;
    assign w_err_next = r_err || (w_consume && mem_resp_err_i);

    assign w_req_cnt_next  = w_req_fire ? (r_req_cnt  + CNT_ONE) : r_req_cnt;
    assign w_resp_cnt_next = w_consume  ? (r_resp_cnt + CNT_ONE) : r_resp_cnt;

    // Word indices wrap in WIDX_W bits, giving critical-word-first order.
    assign w_req_word  = r_crit + r_req_cnt[WIDX_W-1:0];
    assign w_resp_word = r_crit + r_resp_cnt[WIDX_W-1:0];

    assign mem_req_addr_o = {r_tag, r_set, w_req_word, {BOFF_W{1'b0}}};

    assign data_we_o    = r_data_we;
    assign data_way_o   = r_way;
    assign data_set_o   = r_set;
    assign data_word_o  = r_data_word;
    assign data_wdata_o = r_data_wdata;

    assign w_tag_entry  = '{valid: ~r_err, tag: r_tag};
    assign tag_we_o     = (r_state == S_TAG);
    assign tag_way_o    = r_way;
    assign tag_set_o    = r_set;
    assign tag_wdata_o  = tag_we_o ? w_tag_entry : '0;
    assign fill_done_o  = tag_we_o && !r_err;
    assign fill_err_o   = tag_we_o &&  r_err;

    // State register, line latch, fill counters and the registered data write.
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tag        <= '0;
            r_set        <= '0;
            r_way        <= '0;
            r_crit       <= '0;
            r_req_cnt    <= '0;
            r_resp_cnt   <= '0;
            r_err        <= 1'b0;
            r_data_we    <= 1'b0;
            r_data_word  <= '0;
            r_data_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_tag      <= miss_addr_i[ICACHE_ADDR_W-1 -: TAG_W];
                r_set      <= miss_addr_i[OFF_W +: SET_W];
                r_way      <= miss_way_i;
                r_crit     <= miss_addr_i[BOFF_W +: WIDX_W];
                r_req_cnt  <= '0;
                r_resp_cnt <= '0;
                r_err      <= 1'b0;
            end else begin
                r_req_cnt  <= w_req_cnt_next;
                r_resp_cnt <= w_resp_cnt_next;
                r_err      <= w_err_next;
            end
            r_data_we <= w_write;
            if (w_write) begin
                r_data_word  <= w_resp_word;
                r_data_wdata <= mem_resp_data_i;
            end
        end
    end

    // Next-state decode; exits look at post-edge counts so the tag write lands
    // in the same cycle as the last data write.
    // NOTE: default assigned first so no path through the case infers a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_FILL;
            end
            S_FILL: begin
                if (w_resp_cnt_next == CNT_WORDS) w_state_next = S_TAG;
                else if (w_err_next)              w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_resp_cnt_next == r_req_cnt) w_state_next = S_TAG;
            end
            S_TAG: begin
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill. A small memory model answers word
// reads in order with configurable delay, back-pressure, error and reset
// injection. Expected requests, data writes and tag writes are queued when
// the stimulus that causes them is driven, and compared when the DUT emits.
module tb_icache_refill;
    import icache_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     miss_valid_i;
    logic [ICACHE_ADDR_W-1:0] miss_addr_i;
    logic [WAY_W-1:0]         miss_way_i;
    logic                     miss_ready_o;
    logic                     mem_req_valid_o;
    logic [ICACHE_ADDR_W-1:0] mem_req_addr_o;
    logic                     mem_req_ready_i;
    logic                     mem_resp_valid_i;
    logic [MEM_DATA_W-1:0]    mem_resp_data_i;
    logic                     mem_resp_err_i;
    logic                     data_we_o;
    logic [WAY_W-1:0]         data_way_o;
    logic [SET_W-1:0]         data_set_o;
    logic [WIDX_W-1:0]        data_word_o;
    logic [MEM_DATA_W-1:0]    data_wdata_o;
    logic                     tag_we_o;
    logic [WAY_W-1:0]         tag_way_o;
    logic [SET_W-1:0]         tag_set_o;
    logic [TAG_W:0]           tag_wdata_o;
    logic                     fill_done_o;
    logic                     fill_err_o;

    icache_refill dut (
        .clk              (clk),
        .rst              (rst),
        .miss_valid_i     (miss_valid_i),
        .miss_addr_i      (miss_addr_i),
        .miss_way_i       (miss_way_i),
        .miss_ready_o     (miss_ready_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .mem_resp_err_i   (mem_resp_err_i),
        .data_we_o        (data_we_o),
        .data_way_o       (data_way_o),
        .data_set_o       (data_set_o),
        .data_word_o      (data_word_o),
        .data_wdata_o     (data_wdata_o),
        .tag_we_o         (tag_we_o),
        .tag_way_o        (tag_way_o),
        .tag_set_o        (tag_set_o),
        .tag_wdata_o      (tag_wdata_o),
        .fill_done_o      (fill_done_o),
        .fill_err_o       (fill_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ICACHE_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0]    data;
        int                       due;
    } mem_item_t;

    typedef struct {
        logic [WAY_W-1:0]      way;
        logic [SET_W-1:0]      set;
        logic [WIDX_W-1:0]     word;
        logic [MEM_DATA_W-1:0] data;
    } wr_item_t;

    typedef struct {
        logic [WAY_W-1:0] way;
        logic [SET_W-1:0] set;
        logic [TAG_W:0]   entry;
    } tag_item_t;

    mem_item_t                mem_q[$];
    wr_item_t                 wr_q[$];
    tag_item_t                tag_q[$];
    logic [ICACHE_ADDR_W-1:0] req_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Knobs set by the test sequence.
    bit                       bp_mode   = 1'b0;
    bit                       spurious  = 1'b0;
    int                       err_at    = -1;
    int                       rst_at    = -1;
    bit                       miss_pending = 1'b0;
    logic [ICACHE_ADDR_W-1:0] miss_addr = '0;
    logic [WAY_W-1:0]         miss_way  = '0;

    // Per-fill observations.
    logic [SET_W-1:0] cur_set = '0;
    logic [WAY_W-1:0] cur_way = '0;
    int  resp_idx = 0;
    bit  err_seen = 1'b0;
    bit  busy     = 1'b0;
    bit  rst_chk  = 1'b0;
    int  last_due = 0;
    int  n_req = 0, n_wr = 0, n_done = 0, n_err = 0, n_tag = 0, n_rst = 0;
    int  acc_cyc = 0, tag_cyc = 0;
    int  first_req_cyc = -1, last_req_cyc = -1, first_wr_cyc = -1, last_wr_cyc = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: sample DUT outputs at the falling edge, then drive the
    // inputs that the next rising edge will capture.
    task automatic cycle();
        mem_item_t                m;
        wr_item_t                 w;
        tag_item_t                t;
        int                       crit;
        logic [ICACHE_ADDR_W-1:0] a;

        @(negedge clk);
        cyc++;

        if (rst_chk) begin
            rst_chk = 1'b0;
            check("rst_mid_ready", miss_ready_o, 1);
            check("rst_mid_quiet", {mem_req_valid_o, data_we_o, tag_we_o, fill_done_o, fill_err_o}, 0);
        end

        if (busy) check("ready_busy", miss_ready_o, 0);

        if (data_we_o) begin
            n_wr++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            if (wr_q.size() == 0) begin
                check("unexp_write", 1, 0);
            end else begin
                w = wr_q.pop_front();
                check("wr_word", data_word_o, w.word);
                check("wr_data", data_wdata_o, w.data);
                check("wr_way_set", {data_way_o, data_set_o}, {w.way, w.set});
            end
        end

        if (tag_we_o) begin
            n_tag++;
            tag_cyc = cyc;
            busy    = 1'b0;
            if (tag_q.size() == 0) begin
                check("unexp_tag", 1, 0);
            end else begin
                t = tag_q.pop_front();
                check("tag_entry", tag_wdata_o, t.entry);
                check("tag_way_set", {tag_way_o, tag_set_o}, {t.way, t.set});
                check("tag_pulses", {fill_done_o, fill_err_o}, {t.entry[TAG_W], ~t.entry[TAG_W]});
            end
            check("tag_drained", mem_q.size(), 0);
            check("tag_after_writes", wr_q.size(), 0);
            req_q.delete();
        end else if (fill_done_o || fill_err_o) begin
            check("stray_pulse", {fill_done_o, fill_err_o}, 0);
        end
        if (fill_done_o) n_done++;
        if (fill_err_o)  n_err++;

        // Memory response channel.
        rst              = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_err_i   = 1'b0;
        mem_resp_data_i  = '0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = m.data;
            if (resp_idx == rst_at) begin
                rst = 1'b1;
            end else if (resp_idx == err_at) begin
                mem_resp_err_i = 1'b1;
                err_seen       = 1'b1;
            end else if (!err_seen) begin
                w.way  = cur_way;
                w.set  = cur_set;
                w.word = m.addr[OFF_W-1:BOFF_W];
                w.data = m.data;
                wr_q.push_back(w);
            end
            resp_idx++;
        end else if (spurious) begin
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = 32'hDEAD_BEEF;
        end

        if (rst) begin
            mem_q.delete();
            wr_q.delete();
            req_q.delete();
            tag_q.delete();
            miss_valid_i    = 1'b0;
            mem_req_ready_i = 1'b0;
            busy     = 1'b0;
            rst_chk  = 1'b1;
            rst_at   = -1;
            last_due = 0;
            n_rst++;
            return;
        end

        // Memory request channel.
        mem_req_ready_i = bp_mode ? ((cyc % 2) == 0) : 1'b1;
        if (mem_req_valid_o && mem_req_ready_i) begin
            n_req++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            last_req_cyc = cyc;
            if (req_q.size() == 0) check("unexp_req", 1, 0);
            else                   check("req_addr", mem_req_addr_o, req_q.pop_front());
            m.addr = mem_req_addr_o;
            m.data = $urandom();
            m.due  = cyc + 1 + (bp_mode ? int'($urandom_range(0, 5)) : 0);
            if (m.due <= last_due) m.due = last_due + 1;
            last_due = m.due;
            mem_q.push_back(m);
        end

        // Miss request channel.
        miss_valid_i = miss_pending;
        miss_addr_i  = miss_addr;
        miss_way_i   = miss_way;
        if (miss_valid_i && miss_ready_o) begin
            miss_pending  = 1'b0;
            busy          = 1'b1;
            acc_cyc       = cyc;
            cur_set       = miss_addr[OFF_W +: SET_W];
            cur_way       = miss_way;
            resp_idx      = 0;
            err_seen      = 1'b0;
            n_req = 0; n_wr = 0; n_done = 0; n_err = 0;
            first_req_cyc = -1; last_req_cyc = -1;
            first_wr_cyc  = -1; last_wr_cyc  = -1;
            crit = int'(miss_addr[OFF_W-1:BOFF_W]);
            for (int i = 0; i < WORDS; i++) begin
                a = {miss_addr[ICACHE_ADDR_W-1:OFF_W], {OFF_W{1'b0}}}
                    + ICACHE_ADDR_W'(((crit + i) % WORDS) * (MEM_DATA_W / 8));
                req_q.push_back(a);
            end
            t.way   = miss_way;
            t.set   = cur_set;
            t.entry = {(err_at < 0), miss_addr[ICACHE_ADDR_W-1 -: TAG_W]};
            tag_q.push_back(t);
        end
    endtask

    task automatic start_fill(input logic [ICACHE_ADDR_W-1:0] addr, input logic [WAY_W-1:0] way);
        miss_addr    = addr;
        miss_way     = way;
        miss_pending = 1'b1;
    endtask

    task automatic wait_tag(input string tag, input int budget);
        int n0;
        n0 = n_tag;
        for (int k = 0; k < budget && n_tag == n0; k++) cycle();
        if (n_tag == n0) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_accept(input string tag, input int budget);
        for (int k = 0; k < budget && miss_pending; k++) cycle();
        check({tag, "_accept_timeout"}, miss_pending, 0);
    endtask

    initial begin
        int t1;
        int r0;

        rst              = 1'b1;
        miss_valid_i     = 1'b0;
        miss_addr_i      = '0;
        miss_way_i       = '0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        mem_resp_err_i   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", miss_ready_o, 1);
        check("rst_mem", {mem_req_valid_o, mem_req_addr_o}, 0);
        check("rst_data", {data_we_o, data_way_o, data_set_o, data_word_o, data_wdata_o}, 0);
        check("rst_tag", {tag_we_o, tag_way_o, tag_set_o, tag_wdata_o, fill_done_o, fill_err_o}, 0);
        repeat (2) cycle();

        // Zero-wait fill, critical word 13, exact cycle timing.
        start_fill(32'h0000_1234, 1'b1);
        wait_tag("t1", 100);
        check("t1_n_req", n_req, 16);
        check("t1_n_wr", n_wr, 16);
        check("t1_first_req", first_req_cyc - acc_cyc, 1);
        check("t1_last_req", last_req_cyc - acc_cyc, 16);
        check("t1_first_wr", first_wr_cyc - acc_cyc, 3);
        check("t1_last_wr", last_wr_cyc - acc_cyc, 18);
        check("t1_tag_cyc", tag_cyc - acc_cyc, 18);
        check("t1_done", n_done, 1);
        cycle();
        check("t1_ready_back", miss_ready_o, 1);
        check("t1_done_single", n_done, 1);

        // Stray responses while idle must be ignored.
        spurious = 1'b1;
        repeat (3) cycle();
        spurious = 1'b0;
        cycle();
        check("spurious_no_write", n_wr, 16);
        check("spurious_no_req", mem_req_valid_o, 0);

        // Back-pressure and random response delays.
        bp_mode = 1'b1;
        start_fill(32'hABCD_E7E8, 1'b0);
        wait_tag("t2", 600);
        check("t2_n_req", n_req, 16);
        check("t2_n_wr", n_wr, 16);
        check("t2_done", n_done, 1);
        repeat (3) cycle();
        bp_mode = 1'b0;

        // Bus error on response 5.
        err_at = 5;
        start_fill(32'h0000_8000, 1'b1);
        wait_tag("t3", 100);
        check("t3_n_wr", n_wr, 5);
        check("t3_done", n_done, 0);
        check("t3_err", n_err, 1);
        err_at = -1;
        repeat (2) cycle();

        // Second miss held off until the first fill's TAG cycle has passed.
        start_fill(32'h1357_9BC4, 1'b0);
        wait_accept("t4a", 20);
        start_fill(32'h2468_ACE0, 1'b1);
        wait_tag("t4a", 100);
        t1 = tag_cyc;
        wait_accept("t4b", 20);
        check("t4_accept_cycle", acc_cyc - t1, 1);
        wait_tag("t4b", 100);
        check("t4b_n_wr", n_wr, 16);
        check("t4b_done", n_done, 1);
        repeat (2) cycle();

        // Reset during response 8, then a clean fill.
        r0 = n_rst;
        rst_at = 8;
        start_fill(32'h0040_0F1C, 1'b0);
        for (int k = 0; k < 100 && n_rst == r0; k++) cycle();
        check("t5_rst_seen", n_rst - r0, 1);
        t1 = n_tag;
        repeat (5) cycle();
        check("t5_no_tag", n_tag - t1, 0);
        check("t5_no_pulse", n_done + n_err, 0);
        start_fill(32'h0040_0F1C, 1'b1);
        wait_tag("t5", 100);
        check("t5_n_wr", n_wr, 16);
        check("t5_done", n_done, 1);
        repeat (2) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
